// File: rtl/matvec_seq.sv
`default_nettype none
// ============================================================================
//  Module   : matvec_seq (with helper lane array: multiply)
//  Purpose  : Row-streaming matrix-vector sequencer, y = A*x. The vector x
//             is latched once per job. Each accepted row is multiplied
//             lane-wise against x and the lane products are summed. One
//             result per row is emitted, tagged with its row index.
//  Config   : MATVEC_PIPE_EN - when defined, adds a registered product stage
//             ahead of the summing stage (row-to-result latency 2 instead
//             of 1). The handshake protocol and the results are the same in
//             both builds.
//  Revision : 1.0 - initial release
// ============================================================================

// Combinational lane array: Ndata independent unsigned Nbits x Nbits products.
module multiply #(
    parameter int Nbits = 4,
    parameter int Ndata = 3
) (
    input  logic [Ndata*Nbits-1:0]   a,
    input  logic [Ndata*Nbits-1:0]   b,
    output logic [Ndata*2*Nbits-1:0] p
);

    for (genvar i = 0; i < Ndata; i++) begin : g_lane
        // Operands are widened first so that the product keeps its full width.
        assign p[i*2*Nbits +: 2*Nbits] = {{Nbits{1'b0}}, a[i*Nbits +: Nbits]}
                                       * {{Nbits{1'b0}}, b[i*Nbits +: Nbits]};
    end

endmodule

module matvec_seq #(
    parameter  int Nbits = 4,
    parameter  int Ndata = 3,
    localparam int IW    = $clog2(Ndata),
    localparam int RW    = 2*Nbits + $clog2(Ndata)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [Ndata*Nbits-1:0] vec_in,
    input  logic [Ndata*Nbits-1:0] row_in,
    input  logic                   row_valid,
    output logic                   row_ready,
    output logic [RW-1:0]          res_out,
    output logic [IW-1:0]          res_idx,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int              PW       = 2*Nbits;
    localparam int              CW       = $clog2(Ndata+1);
    localparam logic [IW-1:0]   LAST_ROW = IW'(Ndata-1);
    localparam logic [CW-1:0]   RES_END  = CW'(Ndata);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [Ndata*Nbits-1:0] x_reg;
    logic [IW-1:0]          row_cnt;
    logic [CW-1:0]          res_cnt;
    logic [CW-1:0]          res_cnt_nxt;
    logic [Ndata*PW-1:0]    lane_prod;
    logic [Ndata*PW-1:0]    sum_src;
    logic [RW-1:0]          sum;
    logic [IW-1:0]          load_idx;
    logic                   row_fire;
    logic                   res_fire;
    logic                   out_free;
    logic                   out_load;

    multiply #(
        .Nbits (Nbits),
        .Ndata (Ndata)
    ) u_multiply (
        .a (row_in),
        .b (x_reg),
        .p (lane_prod)
    );

    assign row_fire    = row_valid && row_ready;
    assign res_fire    = res_valid && res_ready;
    // The output register can take new data if it is empty or drains now.
    assign out_free    = !res_valid || res_ready;
    assign res_cnt_nxt = res_cnt + CW'(res_fire);
    assign busy        = (state == S_RUN) || (state == S_DRAIN);

`ifdef MATVEC_PIPE_EN
    logic [Ndata*PW-1:0] prod_reg;
    logic [IW-1:0]       prod_idx;
    logic                prod_valid;

    // A row may enter when the product stage is empty or moves on this cycle;
    // this is combinational from res_ready through out_free.
    assign row_ready = (state == S_RUN) && (!prod_valid || out_free);
    assign out_load  = prod_valid && out_free;
    assign sum_src   = prod_reg;
    assign load_idx  = prod_idx;

    // Product stage: capture lane products with their row index; refill on
    // the same cycle that the held entry moves to the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_valid <= 1'b0;
            prod_reg   <= '0;
            prod_idx   <= '0;
        end else if (row_fire) begin
            prod_valid <= 1'b1;
            prod_reg   <= lane_prod;
            prod_idx   <= row_cnt;
        end else if (out_load) begin
            prod_valid <= 1'b0;
        end
    end
`else
    assign row_ready = (state == S_RUN) && out_free;
    assign out_load  = row_fire;
    assign sum_src   = lane_prod;
    assign load_idx  = row_cnt;
`endif

    // Sum of the zero-extended lane products; RW is wide enough that it never wraps.
    always_comb begin
        sum = '0;
        for (int i = 0; i < Ndata; i++) begin
            sum = sum + RW'(sum_src[i*PW +: PW]);
        end
    end

    // Output register: holds the result stable until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_out   <= '0;
            res_idx   <= '0;
        end else if (out_load) begin
            res_valid <= 1'b1;
            res_out   <= sum;
            res_idx   <= load_idx;
        end else if (res_fire) begin
            res_valid <= 1'b0;
        end
    end

    // Job context: x is latched on an accepted start; counters track row and result transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            row_cnt <= '0;
            res_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                x_reg   <= vec_in;
                row_cnt <= '0;
                res_cnt <= '0;
            end
        end else begin
            if (row_fire) begin
                row_cnt <= row_cnt + IW'(1);
            end
            res_cnt <= res_cnt_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DRAIN ends on the cycle the last result is taken.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (row_fire && (row_cnt == LAST_ROW)) next_state = S_DRAIN;
            S_DRAIN: if (res_cnt_nxt == RES_END) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Registered done pulse, high for exactly the one cycle spent in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (next_state == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matvec_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matvec_seq
//  Purpose  : Self-checking bench for matvec_seq. Expected results are pushed
//             to a scoreboard queue when a row is accepted and are compared
//             when the result is taken. Latency expectation follows
//             MATVEC_PIPE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matvec_seq;

    localparam int NB  = 4;
    localparam int ND  = 3;
    localparam int RWB = 2*NB + $clog2(ND);
    localparam int IWB = $clog2(ND);
`ifdef MATVEC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int val;
        int idx;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [ND*NB-1:0]     vec_in;
    logic [ND*NB-1:0]     row_in;
    logic                 row_valid;
    logic                 row_ready;
    logic [RWB-1:0]       res_out;
    logic [IWB-1:0]       res_idx;
    logic                 res_valid;
    logic                 res_ready;
    logic                 busy;
    logic                 done;

    exp_t                 exp_q[$];
    logic [ND*NB-1:0]     xcur;
    int                   row_idx;
    int                   cyc;
    int                   last_res_cyc;
    int                   done_pulses;
    int                   total;
    int                   passed;
    logic                 hold_prev;
    logic [RWB-1:0]       hold_out;
    logic [IWB-1:0]       hold_idx;

    matvec_seq #(
        .Nbits (NB),
        .Ndata (ND)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_in    (vec_in),
        .row_in    (row_in),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .res_out   (res_out),
        .res_idx   (res_idx),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int dot(input logic [ND*NB-1:0] r, input logic [ND*NB-1:0] x);
        int s;
        s = 0;
        for (int i = 0; i < ND; i++) begin
            s += int'(r[i*NB +: NB]) * int'(x[i*NB +: NB]);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Scoreboard push on row acceptance, pop/compare on result transfer,
    // hold-stability and done-timing checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (row_valid && row_ready) begin
                exp_q.push_back('{dot(row_in, xcur), row_idx});
                row_idx++;
            end
            if (hold_prev) begin
                chk("hold_out", 32'(res_out), 32'(hold_out));
                chk("hold_idx", 32'(res_idx), 32'(hold_idx));
            end
            hold_prev = res_valid && !res_ready;
            hold_out  = res_out;
            hold_idx  = res_idx;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_out", 32'(res_out), 32'(e.val));
                    chk("res_idx", 32'(res_idx), 32'(e.idx));
                end
                last_res_cyc = cyc;
            end
            if (done) begin
                done_pulses++;
                chk("done_timing", 32'(cyc), 32'(last_res_cyc + 1));
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic start_job(input logic [ND*NB-1:0] x);
        int ok;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1;
                break;
            end
        end
        chk("idle_before_start", 32'(ok), 32'd1);
        vec_in  = x;
        xcur    = x;
        row_idx = 0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_row(input logic [ND*NB-1:0] r, output int waits);
        int ok;
        ok        = 0;
        waits     = 0;
        row_in    = r;
        row_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (row_ready) begin
                ok = 1;
                break;
            end
            waits++;
        end
        chk("row_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 32'(got), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   w;
        int   k;
        int   saved;
        logic sent2;

        clk = 1'b0; rst_n = 1'b0; start = 1'b0; vec_in = '0; row_in = '0;
        row_valid = 1'b0; res_ready = 1'b1; xcur = '0; row_idx = 0; cyc = 0;
        last_res_cyc = -10; done_pulses = 0; total = 0; passed = 0; hold_prev = 1'b0;
        hold_out = '0; hold_idx = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_row_ready", 32'(row_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_out",   32'(res_out),   32'd0);
        chk("rst_res_idx",   32'(res_idx),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Basic job with latency measurement and an ignored start during RUN
        start_job({4'd3, 4'd2, 4'd1});
        send_row({4'd6, 4'd5, 4'd4}, w);
        row_valid = 1'b0;
        k = 1;
        while (!res_valid && k < 6) begin
            @(posedge clk); #1; k++;
        end
        chk("latency", 32'(k), 32'(LAT));
        start = 1'b1; vec_in = {4'd7, 4'd7, 4'd7};
        @(posedge clk); #1;
        start = 1'b0; vec_in = '0;
        chk("busy_ignored_start", 32'(busy), 32'd1);
        send_row({4'd0, 4'd0, 4'd0}, w);
        send_row({4'd15, 4'd15, 4'd15}, w);
        row_valid = 1'b0;
        wait_done("done_basic");

        // Max values at full throughput
        start_job({4'd15, 4'd15, 4'd15});
        for (int r = 0; r < ND; r++) begin
            send_row({4'd15, 4'd15, 4'd15}, w);
            chk("throughput_waits", 32'(w), 32'd0);
        end
        row_valid = 1'b0;
        wait_done("done_max");

        // Backpressure: sink stalls for 5 cycles after the first row
        start_job({4'd3, 4'd2, 4'd1});
        res_ready = 1'b0;
        send_row({4'd6, 4'd5, 4'd4}, w);
        row_in = {4'd1, 4'd1, 4'd1}; row_valid = 1'b1; sent2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (row_valid && row_ready) sent2 = 1'b1;
            @(posedge clk); #1;
            if (sent2) row_valid = 1'b0;
        end
        chk("bp_row_ready", 32'(row_ready), 32'd0);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        chk("bp_res_out",   32'(res_out),   32'd32);
        chk("bp_res_idx",   32'(res_idx),   32'd0);
        chk("bp_row2_in_stage", 32'(sent2), 32'(LAT == 2));
        res_ready = 1'b1;
        if (!sent2) send_row({4'd1, 4'd1, 4'd1}, w);
        send_row({4'd2, 4'd9, 4'd14}, w);
        row_valid = 1'b0;
        wait_done("done_bp");

        // Reset mid-job after the second row
        start_job({4'd3, 4'd2, 4'd1});
        send_row({4'd6, 4'd5, 4'd4}, w);
        send_row({4'd8, 4'd8, 4'd8}, w);
        row_valid = 1'b0;
        saved = done_pulses;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row_ready", 32'(row_ready), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_out",   32'(res_out),   32'd0);
        chk("mid_rst_res_idx",   32'(res_idx),   32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_done",      32'(done),      32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        start_job({4'd4, 4'd3, 4'd2});
        send_row({4'd1, 4'd2, 4'd3}, w);
        send_row({4'd15, 4'd0, 4'd9}, w);
        send_row({4'd5, 4'd11, 4'd7}, w);
        row_valid = 1'b0;
        wait_done("done_after_rst");
        chk("no_done_from_aborted_job", 32'(done_pulses), 32'(saved + 1));

        // Random row_valid gaps
        for (int j = 0; j < 2; j++) begin
            start_job(12'($urandom_range(0, 4095)));
            for (int r = 0; r < ND; r++) begin
                row_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send_row(12'($urandom_range(0, 4095)), w);
            end
            row_valid = 1'b0;
            wait_done("done_gaps");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
